// File: rtl/aesl_deadlock_report_ctrl.sv
// Deadlock report controller: qualifies monitor block bits with a persistence
// counter, scans monitors round-robin and reports the first blocked index.
module aesl_deadlock_report_ctrl #(
  parameter int unsigned NUM_MON = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned THRESH  = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               top_idle,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [CNT_W-1:0]   report_cycles,
  output logic               deadlock_detect
);

  localparam int unsigned STALL_W = (THRESH > 2) ? $clog2(THRESH) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(THRESH - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_MON - 1);

  typedef enum logic [2:0] {S_IDLE, S_WATCH, S_SCAN, S_REPORT, S_HALT} state_t;

  state_t             state;
  logic [STALL_W-1:0] stall_cnt;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   last_ptr;
  logic [IDX_W-1:0]   scan_n;

  logic               qblk;
  logic               hit;
  logic [CNT_W-1:0]   cyc_inc;
  logic [IDX_W-1:0]   ptr_wrap;
  logic [IDX_W-1:0]   start_ptr;

  always_comb begin
    qblk      = (|mon_block) & ~top_idle;
    hit       = mon_block[ptr] & ~top_idle;
    cyc_inc   = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 1'b1;
    ptr_wrap  = (ptr == IDX_LAST) ? '0 : ptr + 1'b1;
    start_ptr = (last_ptr == IDX_LAST) ? '0 : last_ptr + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      stall_cnt       <= '0;
      cyc_cnt         <= '0;
      ptr             <= '0;
      scan_n          <= '0;
      last_ptr        <= IDX_LAST;
      report_valid    <= 1'b0;
      report_idx      <= '0;
      report_cycles   <= '0;
      deadlock_detect <= 1'b0;
    end else if (clear) begin
      // last_ptr survives a clear so the next scan resumes after the last report
      state           <= S_IDLE;
      stall_cnt       <= '0;
      cyc_cnt         <= '0;
      ptr             <= '0;
      scan_n          <= '0;
      report_valid    <= 1'b0;
      report_idx      <= '0;
      report_cycles   <= '0;
      deadlock_detect <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          stall_cnt <= '0;
          cyc_cnt   <= '0;
          if (enable) state <= S_WATCH;
        end
        S_WATCH: begin
          if (!enable) begin
            state     <= S_IDLE;
            stall_cnt <= '0;
            cyc_cnt   <= '0;
          end else begin
            cyc_cnt <= cyc_inc;
            if (qblk) begin
              if (stall_cnt == STALL_LAST) begin
                state     <= S_SCAN;
                stall_cnt <= '0;
                ptr       <= start_ptr;
                scan_n    <= '0;
              end else begin
                stall_cnt <= stall_cnt + 1'b1;
              end
            end else begin
              stall_cnt <= '0;
            end
          end
        end
        S_SCAN: begin
          if (!enable) begin
            state     <= S_IDLE;
            stall_cnt <= '0;
            cyc_cnt   <= '0;
          end else begin
            cyc_cnt <= cyc_inc;
            if (hit) begin
              state         <= S_REPORT;
              report_valid  <= 1'b1;
              report_idx    <= ptr;
              report_cycles <= cyc_inc;
              last_ptr      <= ptr;
            end else if (scan_n == IDX_LAST) begin
              state     <= S_WATCH;
              stall_cnt <= '0;
            end else begin
              ptr    <= ptr_wrap;
              scan_n <= scan_n + 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (report_ready) begin
            state           <= S_HALT;
            report_valid    <= 1'b0;
            deadlock_detect <= 1'b1;
          end
        end
        S_HALT: begin
          deadlock_detect <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
